// File: rtl/mips32_mem_responder.sv
// Memory responder for the MIPS32 core: one single-port word memory shared by the
// instruction-fetch port (read-only) and the data port (LW/SW), round-robin arbitrated.
// Latency: grant at T -> rvalid at T+2+WAIT_CYC; one access per 3+WAIT_CYC cycles.
// Backpressure: gnt is only offered in IDLE; requesters hold req until gnt.
//
// Ports:
//   clk1, rst_n                      clock (posedge) and async active-low reset
//   if_req/if_addr -> if_gnt/if_rvalid/if_rdata            fetch port
//   dm_req/dm_we/dm_addr/dm_wdata -> dm_gnt/dm_rvalid/dm_rdata   data port
//   busy                             a transaction is in flight
//   err                              out-of-range access, pulses with rvalid
// Build option: define MEMRSP_RANGE_ERR_EN to reject addresses with addr[31:ADDR_W] != 0
// (no access, err=1, rdata=0). Without it the address wraps modulo 2**ADDR_W and err is 0.

module mips32_mem_responder #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              busy,
    output logic              err
);

    // The RESP state covers the rvalid cycle so the next grant lands one cycle later.
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          wait_cnt;
    logic                last_dm;
    logic                grant_dm;
    logic                grant_if;
    logic [31:0]         addr_sel;
    logic                lat_dm;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic                access_oor;
    logic                mem_we;
    logic [DATA_W-1:0]   rd_word;

    logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];

    // Arbitration: a lone requester wins; on a tie the port not served last wins.
    // Gating with rst_n keeps gnt low while reset is asserted.
    always_comb begin
        grant_dm = 1'b0;
        grant_if = 1'b0;
        if (rst_n && state == S_IDLE) begin
            grant_dm = dm_req && (!if_req || !last_dm);
            grant_if = if_req && !grant_dm;
        end
    end

    assign if_gnt   = grant_if;
    assign dm_gnt   = grant_dm;
    assign addr_sel = grant_dm ? dm_addr : if_addr;
    assign busy     = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant_dm || grant_if)
                    state_nxt = (WAIT_CYC > 0) ? S_WAIT : S_ACCESS;
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0)
                    state_nxt = S_ACCESS;
            end
            S_ACCESS: state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            last_dm   <= 1'b0;
            lat_dm    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (grant_dm || grant_if) begin
                lat_dm    <= grant_dm;
                lat_we    <= grant_dm && dm_we;
                lat_addr  <= addr_sel[ADDR_W-1:0];
                lat_wdata <= dm_wdata;
                last_dm   <= grant_dm;
                wait_cnt  <= WAIT_LOAD;
            end else if (state == S_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

`ifdef MEMRSP_RANGE_ERR_EN
    logic lat_oor;
    logic err_q;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n)
            lat_oor <= 1'b0;
        else if (grant_dm || grant_if)
            lat_oor <= |addr_sel[31:ADDR_W];
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else
            err_q <= (state == S_ACCESS) && lat_oor;
    end

    assign access_oor = lat_oor;
    assign err        = err_q;
`else
    // High address bits are deliberately dropped: the address wraps.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_sel[31:ADDR_W];
    assign access_oor     = 1'b0;
    assign err            = 1'b0;
`endif

    assign mem_we  = (state == S_ACCESS) && lat_we && !access_oor;
    assign rd_word = access_oor ? '0 : mem[lat_addr];

    // Storage is not reset; reset forces IDLE so an in-flight store never lands.
    always_ff @(posedge clk1) begin
        if (mem_we)
            mem[lat_addr] <= lat_wdata;
    end

    // Response registers: a store leaves dm_rdata untouched, the idle port stays quiet.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            if (state == S_ACCESS) begin
                if (lat_dm) begin
                    dm_rvalid <= 1'b1;
                    if (!lat_we)
                        dm_rdata <= rd_word;
                end else begin
                    if_rvalid <= 1'b1;
                    if_rdata  <= rd_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_mips32_mem_responder.sv
module tb_mips32_mem_responder;

    localparam int TB_WAIT = 1;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        busy, err;

    // Shared stimulus for the WAIT_CYC=0 and WAIT_CYC=15 instances.
    logic        x_dm_req = 1'b0;
    logic        x_dm_we = 1'b0;
    logic [31:0] x_dm_addr = '0;
    logic [31:0] x_dm_wdata = '0;
    logic        a_if_gnt, a_if_rvalid, a_dm_gnt, a_dm_rvalid, a_busy, a_err;
    logic [31:0] a_if_rdata, a_dm_rdata;
    logic        b_if_gnt, b_if_rvalid, b_dm_gnt, b_dm_rvalid, b_busy, b_err;
    logic [31:0] b_if_rdata, b_dm_rdata;

    mips32_mem_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_CYC(TB_WAIT)) dut (
        .clk1(clk1), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .busy(busy), .err(err)
    );

    mips32_mem_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_CYC(0)) dut_w0 (
        .clk1(clk1), .rst_n(rst_n),
        .if_req(1'b0), .if_addr(32'd0), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .dm_req(x_dm_req), .dm_we(x_dm_we), .dm_addr(x_dm_addr), .dm_wdata(x_dm_wdata),
        .dm_gnt(a_dm_gnt), .dm_rvalid(a_dm_rvalid), .dm_rdata(a_dm_rdata),
        .busy(a_busy), .err(a_err)
    );

    mips32_mem_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_CYC(15)) dut_w15 (
        .clk1(clk1), .rst_n(rst_n),
        .if_req(1'b0), .if_addr(32'd0), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .dm_req(x_dm_req), .dm_we(x_dm_we), .dm_addr(x_dm_addr), .dm_wdata(x_dm_wdata),
        .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
        .busy(b_busy), .err(b_err)
    );

    always #5 clk1 = ~clk1;

    int cyc = 0;
    always @(posedge clk1) cyc++;

    typedef struct {
        bit          is_dm;
        logic [31:0] dat;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    int          last_rv_cyc = -1;
    logic [31:0] model_mem [0:1023];
    logic [31:0] model_dm_rdata = '0;

    // Scoreboard consumer: every rvalid pops one expectation.
    exp_t        mon_e;
    logic [31:0] mon_got;
    always @(negedge clk1) begin
        if (if_rvalid || dm_rvalid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid: if_rvalid=%0b dm_rvalid=%0b at cycle %0d, none expected",
                         if_rvalid, dm_rvalid, cyc);
            end else begin
                mon_e   = sb_q.pop_front();
                mon_got = mon_e.is_dm ? dm_rdata : if_rdata;
                if ({if_rvalid, dm_rvalid} !== (mon_e.is_dm ? 2'b01 : 2'b10) ||
                    mon_got !== mon_e.dat || err !== mon_e.err) begin
                    errors++;
                    $display("FAIL response: got if_rv=%0b dm_rv=%0b rdata=%h err=%0b, want port_dm=%0b rdata=%h err=%0b",
                             if_rvalid, dm_rvalid, mon_got, err, mon_e.is_dm, mon_e.dat, mon_e.err);
                end
            end
            last_rv_cyc = cyc;
        end
    end

    // Model of one granted access; returns the expectation for its rvalid.
    task automatic push_exp(input bit is_dm, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        logic oor;
`ifdef MEMRSP_RANGE_ERR_EN
        oor = |addr[31:10];
`else
        oor = 1'b0;
`endif
        e.is_dm = is_dm;
        e.err   = oor;
        if (is_dm && we) begin
            if (!oor) model_mem[addr[9:0]] = wdata;
            e.dat = model_dm_rdata;
        end else begin
            e.dat = oor ? 32'd0 : model_mem[addr[9:0]];
            if (is_dm) model_dm_rdata = e.dat;
        end
        sb_q.push_back(e);
    endtask

    task automatic do_req(input bit is_dm, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit push, output int gcyc);
        @(posedge clk1); #1;
        if (is_dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        gcyc = -1;
        for (int i = 0; i < 50 && gcyc < 0; i++) begin
            @(negedge clk1);
            if (is_dm ? dm_gnt : if_gnt) begin
                gcyc = cyc;
                if (push) push_exp(is_dm, we, addr, wdata);
            end
        end
        @(posedge clk1); #1;
        dm_req = 1'b0; if_req = 1'b0;
        dm_we = 1'b0; dm_addr = 32'hFFFF_FFFF; if_addr = 32'hFFFF_FFFF; dm_wdata = 32'h0BAD_0BAD;
        checks++;
        if (gcyc < 0) begin
            errors++;
            $display("FAIL grant_timeout: no gnt for port_dm=%0b addr=%h within 50 cycles", is_dm, addr);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(posedge clk1);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL rvalid_timeout: %0d responses still outstanding, want 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_latency(input string name, input int gcyc);
        checks++;
        if (last_rv_cyc - gcyc !== 2 + TB_WAIT) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, want %0d", name, last_rv_cyc - gcyc, 2 + TB_WAIT);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk1); #1;
        rst_n = 1'b0;
        model_dm_rdata = '0;
        repeat (2) @(posedge clk1);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #10;
        checks++;
        if ({if_gnt, if_rvalid, dm_gnt, dm_rvalid, busy, err} !== 6'b0 || if_rdata !== 32'd0 || dm_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: gnt/rv/busy/err=%b if_rdata=%h dm_rdata=%h, want all zero",
                     {if_gnt, if_rvalid, dm_gnt, dm_rvalid, busy, err}, if_rdata, dm_rdata);
        end
        @(posedge clk1); #1 rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        int g;
        do_req(1'b1, 1'b1, 32'd5, 32'h2AAA_0001, 1'b1, g);
        wait_done();
        check_latency("store5", g);
        do_req(1'b0, 1'b0, 32'd5, 32'd0, 1'b1, g);
        wait_done();
        check_latency("fetch5", g);
    endtask

    task automatic test_store_load();
        int g;
        do_req(1'b1, 1'b0, 32'd5, 32'd0, 1'b1, g);
        wait_done();
        do_req(1'b1, 1'b1, 32'd20, 32'hDEAD_BEEF, 1'b1, g);
        wait_done();
        check_latency("store20", g);
        do_req(1'b1, 1'b0, 32'd20, 32'd0, 1'b1, g);
        wait_done();
        check_latency("load20", g);
    endtask

    task automatic test_arbitration();
        int n;
        bit want_dm;
        @(posedge clk1); #1;
        rst_n = 1'b0;
        model_dm_rdata = '0;
        if_req = 1'b1; if_addr = 32'd5;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd20;
        @(negedge clk1);
        checks++;
        if ({dm_gnt, if_gnt} !== 2'b00) begin
            errors++;
            $display("FAIL gnt_in_reset: dm_gnt,if_gnt=%b, want 00", {dm_gnt, if_gnt});
        end
        @(posedge clk1); #1 rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 80 && n < 6; i++) begin
            @(negedge clk1);
            if (dm_gnt || if_gnt) begin
                want_dm = (n % 2 == 0);
                checks++;
                if ({dm_gnt, if_gnt} !== (want_dm ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL arb_order: grant %0d dm_gnt,if_gnt=%b, want %b",
                             n, {dm_gnt, if_gnt}, want_dm ? 2'b10 : 2'b01);
                end
                push_exp(dm_gnt, 1'b0, dm_gnt ? dm_addr : if_addr, 32'd0);
                n++;
            end
        end
        @(posedge clk1); #1;
        if_req = 1'b0; dm_req = 1'b0;
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL arb_grants: got %0d grants, want 6", n);
        end
        wait_done();
    endtask

    task automatic test_reset_mid();
        int g;
        do_req(1'b1, 1'b1, 32'd20, 32'h1234_5678, 1'b0, g);
        rst_n = 1'b0;
        model_dm_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk1);
            checks++;
            if ({if_gnt, if_rvalid, dm_gnt, dm_rvalid, busy, err} !== 6'b0 || if_rdata !== 32'd0 || dm_rdata !== 32'd0) begin
                errors++;
                $display("FAIL mid_reset_outputs: flags=%b if_rdata=%h dm_rdata=%h, want zero",
                         {if_gnt, if_rvalid, dm_gnt, dm_rvalid, busy, err}, if_rdata, dm_rdata);
            end
        end
        @(posedge clk1); #1 rst_n = 1'b1;
        do_req(1'b1, 1'b0, 32'd20, 32'd0, 1'b1, g);
        wait_done();
    endtask

    task automatic test_range();
        int g;
        do_req(1'b1, 1'b1, 32'd0, 32'h0BAD_F00D, 1'b1, g);
        wait_done();
        do_req(1'b1, 1'b0, 32'h0000_0400, 32'd0, 1'b1, g);
        wait_done();
        do_req(1'b1, 1'b1, 32'h0000_0400, 32'h5555_AAAA, 1'b1, g);
        wait_done();
        do_req(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, g);
        wait_done();
        do_req(1'b0, 1'b0, 32'h8000_0005, 32'd0, 1'b1, g);
        wait_done();
    endtask

    task automatic test_back_to_back();
        int g[3];
        int n;
        @(posedge clk1); #1;
        if_req = 1'b1; if_addr = 32'd5;
        n = 0;
        for (int i = 0; i < 60 && n < 3; i++) begin
            @(negedge clk1);
            if (if_gnt) begin
                g[n] = cyc;
                push_exp(1'b0, 1'b0, 32'd5, 32'd0);
                n++;
            end
        end
        @(posedge clk1); #1 if_req = 1'b0;
        checks++;
        if (n != 3 || g[1] - g[0] != 3 + TB_WAIT || g[2] - g[1] != 3 + TB_WAIT) begin
            errors++;
            $display("FAIL b2b_spacing: grants=%0d gaps=%0d,%0d, want 3 grants gap %0d",
                     n, g[1] - g[0], g[2] - g[1], 3 + TB_WAIT);
        end
        wait_done();
    endtask

    task automatic x_access(input bit we, input logic [31:0] wdata, input logic [31:0] want_a,
                            input logic [31:0] want_b, input string name);
        int ga, gb, ra, rb;
        @(posedge clk1); #1;
        x_dm_req = 1'b1; x_dm_we = we; x_dm_addr = 32'd7; x_dm_wdata = wdata;
        ga = -1; gb = -1; ra = -1; rb = -1;
        for (int i = 0; i < 40 && (ra < 0 || rb < 0); i++) begin
            @(negedge clk1);
            if (a_dm_gnt && ga < 0) ga = cyc;
            if (b_dm_gnt && gb < 0) gb = cyc;
            if (a_dm_rvalid && ra < 0) begin ra = cyc; if (a_dm_rdata !== want_a) begin errors++;
                $display("FAIL %s_w0_data: got %h, want %h", name, a_dm_rdata, want_a); end end
            if (b_dm_rvalid && rb < 0) begin rb = cyc; if (b_dm_rdata !== want_b) begin errors++;
                $display("FAIL %s_w15_data: got %h, want %h", name, b_dm_rdata, want_b); end end
            if (ga >= 0 && gb >= 0) begin
                @(posedge clk1); #1 x_dm_req = 1'b0;
            end
        end
        x_dm_req = 1'b0;
        checks += 2;
        if (ga < 0 || ra - ga != 2) begin
            errors++;
            $display("FAIL %s_w0_latency: got %0d, want 2", name, ra - ga);
        end
        if (gb < 0 || rb - gb != 17) begin
            errors++;
            $display("FAIL %s_w15_latency: got %0d, want 17", name, rb - gb);
        end
    endtask

    task automatic test_wait_extremes();
        x_access(1'b1, 32'hCAFE_0007, 32'd0, 32'd0, "x_store");
        checks++;
        x_access(1'b0, 32'd0, 32'hCAFE_0007, 32'hCAFE_0007, "x_load");
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) model_mem[i] = 'x;
        test_reset();
        test_fetch();
        test_store_load();
        test_arbitration();
        test_reset_mid();
        test_range();
        test_back_to_back();
        test_wait_extremes();
        repeat (3) @(posedge clk1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
